message_scroller: RTL and testbench



---
 rtl/message_scroller.sv | 113 +++++++++++
 tb/tb_message_scroller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/message_scroller.sv
// Symbol buffer and 8-digit window generator for the seven-segment scan driver.
// Shows the message statically in IDLE, or scrolls it right-to-left with a blank gap.
module message_scroller #(
  parameter int          MSG_DEPTH = 16,
  parameter int          TICK_DIV  = 50_000_000,
  parameter logic [4:0]  BLANK     = 5'd31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [4:0]  wr_data,
  input  logic [4:0]  msg_len,
  input  logic        once,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic        wrap,
  output logic [39:0] period_show
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {IDLE, SCROLL} state_t;

  state_t          state;
  logic [4:0]      mem [MSG_DEPTH];
  logic [4:0]      len_q;
  logic            once_q;
  logic [4:0]      pos;
  logic [CW-1:0]   cnt;
  logic [4:0]      len_c;
  logic [5:0]      n_len;
  logic [5:0]      idx;
  logic [39:0]     show;

  assign len_c = (msg_len > 5'(MSG_DEPTH)) ? 5'(MSG_DEPTH) : msg_len;
  assign n_len = {1'b0, len_q} + 6'd8;

  // pos+k < 2N, so one conditional subtract wraps the stream index
  always_comb begin
    show = '1;
    idx  = '0;
    for (int k = 0; k < 8; k++) begin
      if (state == IDLE) begin
        if (5'(k) < len_c) show[39-5*k -: 5] = mem[4'(k)];
      end else begin
        idx = {1'b0, pos} + 6'(k);
        if (idx >= n_len) idx = idx - n_len;
        if (idx < {1'b0, len_q}) show[39-5*k -: 5] = mem[idx[3:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_DEPTH; i++) mem[i] <= BLANK;
      state       <= IDLE;
      pos         <= '0;
      cnt         <= '0;
      len_q       <= '0;
      once_q      <= 1'b0;
      busy        <= 1'b0;
      wrap        <= 1'b0;
      period_show <= '1;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      period_show <= show;
      wrap        <= 1'b0;
      case (state)
        IDLE: begin
          if (start && len_c != 5'd0) begin
            len_q  <= len_c;
            once_q <= once;
            pos    <= '0;
            cnt    <= '0;
            state  <= SCROLL;
            busy   <= 1'b1;
          end
        end
        SCROLL: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            pos   <= '0;
            cnt   <= '0;
          end else if (start) begin
            len_q  <= len_c;
            once_q <= once;
            pos    <= '0;
            cnt    <= '0;
          end else if (cnt == CW'(TICK_DIV - 1)) begin
            cnt <= '0;
            if ({1'b0, pos} == n_len - 6'd1) begin
              pos  <= '0;
              wrap <= 1'b1;
              if (once_q) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              pos <= pos + 5'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_message_scroller.sv
// Bench for message_scroller: elapsed-time reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_message_scroller;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [4:0]  wr_data;
  logic [4:0]  msg_len;
  logic        once, start, stop;
  logic        busy, wrap;
  logic [39:0] period_show;

  message_scroller #(.MSG_DEPTH(16), .TICK_DIV(TD), .BLANK(5'd31)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .once(once), .start(start), .stop(stop),
    .busy(busy), .wrap(wrap), .period_show(period_show)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: position derived from cycles elapsed since start.
  logic [4:0]  mbuf [16];
  logic        m_scr  = 1'b0;
  int          me     = 0;
  int          mlen   = 0;
  logic        monce  = 1'b0;
  logic [39:0] exp_ps = '1;
  logic        exp_busy = 1'b0, exp_wrap = 1'b0;

  initial for (int i = 0; i < 16; i++) mbuf[i] = 5'd31;

  always @(posedge clk) begin
    int lc, n, p, ix;
    logic [39:0] ps;
    lc = (msg_len > 16) ? 16 : int'(msg_len);
    ps = '1;
    if (!m_scr) begin
      for (int k = 0; k < 8; k++) if (k < lc) ps[39-5*k -: 5] = mbuf[k];
    end else begin
      n = mlen + 8;
      p = (me / TD) % n;
      for (int k = 0; k < 8; k++) begin
        ix = (p + k) % n;
        if (ix < mlen) ps[39-5*k -: 5] = mbuf[ix];
      end
    end
    exp_wrap = 1'b0;
    if (rst) begin
      for (int i = 0; i < 16; i++) mbuf[i] = 5'd31;
      m_scr = 1'b0; me = 0; mlen = 0; monce = 1'b0;
      exp_ps = '1;
    end else begin
      exp_ps = ps;
      if (wr_en) mbuf[wr_addr] = wr_data;
      if (m_scr) begin
        if (stop) m_scr = 1'b0;
        else if (start) begin mlen = lc; monce = once; me = 0; end
        else begin
          me++;
          if (me % (TD * (mlen + 8)) == 0) begin
            exp_wrap = 1'b1;
            if (monce) m_scr = 1'b0;
          end
        end
      end else if (start && lc > 0) begin
        m_scr = 1'b1; mlen = lc; monce = once; me = 0;
      end
    end
    exp_busy = m_scr;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("period_show", period_show, exp_ps);
      check("busy", {39'd0, busy}, {39'd0, exp_busy});
      check("wrap", {39'd0, wrap}, {39'd0, exp_wrap});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_wrap(output int c);
    c = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      c++;
      if (wrap) return;
    end
    c = -1;
  endtask

  initial begin
    logic [4:0] msg [5];
    int c;
    msg[0] = 5'd16; msg[1] = 5'd14; msg[2] = 5'd19; msg[3] = 5'd19; msg[4] = 5'd21;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; msg_len = '0;
    once = 1'b0; start = 1'b0; stop = 1'b0;
    step(); step();
    check("rst_show", period_show, 40'hFF_FFFF_FFFF);
    check("rst_busy", {39'd0, busy}, 40'd0);
    check("rst_wrap", {39'd0, wrap}, 40'd0);
    chk_en = 1'b1;
    rst = 1'b0;

    // a reset must clear a previously written entry
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 5'd7;
    step();
    wr_en = 1'b0; rst = 1'b1; msg_len = 5'd1;
    step();
    rst = 1'b0;
    step();
    check("rst_clears_buf", period_show, 40'hFF_FFFF_FFFF);

    // static display
    msg_len = 5'd5;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = msg[i];
      step();
    end
    wr_en = 1'b0;
    step();
    check("static_show", period_show, 40'h83A73AFFFF);
    check("model_static", exp_ps, 40'h83A73AFFFF);
    msg_len = 5'd3;
    step();
    check("static_len3", period_show, 40'h83A7FFFFFF);

    // scroll one step, looping mode
    msg_len = 5'd5; once = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("scroll_pos1", period_show, 40'h74E75FFFFF);
    check("model_pos1", exp_ps, 40'h74E75FFFFF);
    check("scroll_busy", {39'd0, busy}, 40'd1);
    wait_wrap(c);
    wait_wrap(c);
    check("loop_wrap_gap", 40'(c), 40'd52);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_busy", {39'd0, busy}, 40'd0);

    // single pass
    once = 1'b1; start = 1'b1;
    step();
    start = 1'b0; once = 1'b0;
    wait_wrap(c);
    check("once_wrap_cycles", 40'(c), 40'd52);
    check("once_busy_low", {39'd0, busy}, 40'd0);
    step();
    check("once_wrap_pulse", {39'd0, wrap}, 40'd0);
    check("once_show", period_show, 40'h83A73AFFFF);

    // zero-length start is ignored
    msg_len = 5'd0; start = 1'b1;
    step();
    start = 1'b0;
    check("len0_busy", {39'd0, busy}, 40'd0);

    // over-long length clamps to 16, N = 24
    msg_len = 5'd20; once = 1'b1; start = 1'b1;
    step();
    start = 1'b0; once = 1'b0; msg_len = 5'd3;
    wait_wrap(c);
    check("clamp_wrap_cycles", 40'(c), 40'd96);

    // stop wins over start
    msg_len = 5'd5; start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    check("stop_start_busy", {39'd0, busy}, 40'd0);

    // reset mid-scroll at pos = 7
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (28) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", {39'd0, busy}, 40'd0);
    check("midrst_show", period_show, 40'hFF_FFFF_FFFF);
    step(); step();
    check("midrst_buf_blank", period_show, 40'hFF_FFFF_FFFF);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(599) == 0);
      wr_en   = ($urandom_range(3) == 0);
      wr_addr = 4'($urandom_range(15));
      wr_data = 5'($urandom_range(31));
      if ($urandom_range(15) == 0) msg_len = 5'($urandom_range(20));
      once    = 1'($urandom_range(1));
      start   = ($urandom_range(149) == 0);
      stop    = ($urandom_range(299) == 0);
      step();
    end
    rst = 1'b0; wr_en = 1'b0; start = 1'b0; stop = 1'b0;
    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
